// File: rtl/player_physics_y.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | player_physics_y                                                         |
// | Vertical motion engine: gravity, jump launch, landing on map tiles/floor.|
// | Optional feature macro: PLAYER_DOUBLE_JUMP_EN (one extra airborne jump). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module player_physics_y #(
    parameter int TICK_CYCLES = 2000000,
    parameter int Y_W         = 10,
    parameter int V_W         = 6,
    parameter int GROUND_Y    = 448,
    parameter int CEIL_Y      = 20,
    parameter int JUMP_V      = 15,
    parameter int GRAVITY     = 1,
    parameter int VMAX_FALL   = 8,
    parameter int MAP_ROW_OFS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_key,
    input  logic [10:0]           xpos,
    input  logic [3:0]            rgb_pixel,
    output logic [15:0]           pixel_adr,
    output logic [Y_W-1:0]        player_ypos,
    output logic signed [V_W-1:0] velocity,
    output logic                  on_ground
);

    localparam int c_CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0]    c_TICK_LAST = c_CNT_W'(TICK_CYCLES - 1);
    localparam logic signed [V_W:0]   c_GRAV      = (V_W+1)'(GRAVITY);
    localparam logic signed [V_W:0]   c_VMAX      = (V_W+1)'(VMAX_FALL);
    localparam logic signed [V_W-1:0] c_JUMP      = V_W'(-JUMP_V);
    localparam logic signed [Y_W:0]   c_GROUND_S  = (Y_W+1)'(GROUND_Y);
    localparam logic signed [Y_W:0]   c_CEIL_S    = (Y_W+1)'(CEIL_Y);
    localparam logic [Y_W-1:0]        c_GROUND_Y  = Y_W'(GROUND_Y);
    localparam logic [Y_W-1:0]        c_CEIL_Y    = Y_W'(CEIL_Y);
    localparam logic [6:0]            c_ROW_OFS   = 7'(MAP_ROW_OFS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADDR   = 2'd1,
        S_WAIT   = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [c_CNT_W-1:0]    r_tick_cnt;
    logic                  w_tick;
    logic                  r_key_q, r_key_prev, w_key_rise, r_jump_req;
    logic                  w_jump_ok, w_take_jump, w_solid;
    logic signed [V_W:0]   w_v_inc;
    logic signed [V_W-1:0] w_v_base, w_v_nxt;
    logic                  w_og_base, w_og_nxt;
    logic signed [Y_W:0]   w_y_sum;
    logic [Y_W-1:0]        w_y_nxt;

    // Free-running tick counter; the FSM never holds it back.
    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst)         r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_tick) w_state_nxt = S_ADDR;
            S_ADDR:   w_state_nxt = S_WAIT;
            S_WAIT:   w_state_nxt = S_UPDATE;
            S_UPDATE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Set beats clear so a press landing on the UPDATE cycle survives.
    assign w_key_rise = r_key_q & ~r_key_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_q    <= 1'b0;
            r_key_prev <= 1'b0;
            r_jump_req <= 1'b0;
        end else begin
            r_key_q    <= jump_key;
            r_key_prev <= r_key_q;
            if (w_key_rise)                r_jump_req <= 1'b1;
            else if (r_state == S_UPDATE)  r_jump_req <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            pixel_adr <= '0;
        else if (r_state == S_ADDR)
            pixel_adr <= {7'(player_ypos >> 2) + c_ROW_OFS, 9'(xpos >> 2)};
    end

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic r_air_used;

    assign w_jump_ok = on_ground || !r_air_used;

    always_ff @(posedge clk) begin
        if (rst)
            r_air_used <= 1'b0;
        else if (r_state == S_UPDATE) begin
            if (w_og_nxt)                      r_air_used <= 1'b0;
            else if (w_take_jump && !on_ground) r_air_used <= 1'b1;
        end
    end
`else
    assign w_jump_ok = on_ground;
`endif

    assign w_solid = (rgb_pixel != 4'd0) || (player_ypos >= c_GROUND_Y);

    always_comb begin
        w_take_jump = r_jump_req && w_jump_ok;
        w_v_inc     = {velocity[V_W-1], velocity} + c_GRAV;
        w_v_base    = velocity;
        w_og_base   = 1'b0;
        if (w_take_jump)
            w_v_base = c_JUMP;
        else if (!velocity[V_W-1] && w_solid) begin
            w_v_base  = '0;
            w_og_base = 1'b1;
        end else if (w_v_inc > c_VMAX)
            w_v_base = c_VMAX[V_W-1:0];
        else
            w_v_base = w_v_inc[V_W-1:0];

        // Position uses the freshly chosen velocity, then clamps to the play band.
        w_y_sum  = {1'b0, player_ypos} + {{(Y_W+1-V_W){w_v_base[V_W-1]}}, w_v_base};
        w_y_nxt  = w_y_sum[Y_W-1:0];
        w_v_nxt  = w_v_base;
        w_og_nxt = w_og_base;
        if (w_y_sum < c_CEIL_S) begin
            w_y_nxt = c_CEIL_Y;
            w_v_nxt = '0;
        end else if (w_y_sum > c_GROUND_S) begin
            w_y_nxt  = c_GROUND_Y;
            w_v_nxt  = '0;
            w_og_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            player_ypos <= c_GROUND_Y;
            velocity    <= '0;
            on_ground   <= 1'b1;
        end else if (r_state == S_UPDATE) begin
            player_ypos <= w_y_nxt;
            velocity    <= w_v_nxt;
            on_ground   <= w_og_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_player_physics_y.sv
`default_nettype none
// Randomized bench for player_physics_y: two instances (default jump and a
// strong jump that reaches the ceiling) checked against a per-tick model.
module tb_player_physics_y;

    localparam int TICK   = 8;
    localparam int GROUND = 448;
    localparam int CEIL   = 20;
    localparam int VMAX   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        jump_key;
    logic [10:0] xpos;
    logic [3:0]  rgb_a = 4'd0;
    logic [3:0]  rgb_b = 4'd0;
    logic [15:0] adr_a, adr_b;
    logic [9:0]  y_a, y_b;
    logic signed [5:0] v_a, v_b;
    logic        og_a, og_b;

    player_physics_y #(.TICK_CYCLES(TICK)) dut_a (
        .clk(clk), .rst(rst), .jump_key(jump_key), .xpos(xpos),
        .rgb_pixel(rgb_a), .pixel_adr(adr_a), .player_ypos(y_a),
        .velocity(v_a), .on_ground(og_a));

    player_physics_y #(.TICK_CYCLES(TICK), .JUMP_V(31)) dut_b (
        .clk(clk), .rst(rst), .jump_key(jump_key), .xpos(xpos),
        .rgb_pixel(rgb_b), .pixel_adr(adr_b), .player_ypos(y_b),
        .velocity(v_b), .on_ground(og_b));

    // Background map: a solid platform band of rows 70..80, columns 50..99.
    function automatic logic [3:0] map_px(input logic [15:0] adr);
        int row = int'(adr[15:9]);
        int col = int'(adr[8:0]);
        if (row >= 70 && row <= 80 && col >= 50 && col < 100) return 4'h3;
        return 4'h0;
    endfunction

    // One-cycle-latency map ROM
    always @(posedge clk) begin
        rgb_a <= map_px(adr_a);
        rgb_b <= map_px(adr_b);
    end

    typedef struct {
        int y;
        int v;
        bit og;
        bit air;
    } mst_t;

    mst_t ma, mb;
    bit   req;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mst_t reset_state();
        mst_t s;
        s.y = GROUND; s.v = 0; s.og = 1'b1; s.air = 1'b0;
        return s;
    endfunction

    function automatic int exp_adr(input int y, input logic [10:0] x);
        return ((((y / 4) + 2) % 128) * 512) + (int'(x) / 4);
    endfunction

    // One physics tick of the reference behaviour.
    function automatic mst_t commit(input mst_t s, input int jv, input bit rq, input bit px);
        mst_t n = s;
        bit solid = px || (s.y >= GROUND);
        bit allowed;
`ifdef PLAYER_DOUBLE_JUMP_EN
        allowed = s.og || !s.air;
`else
        allowed = s.og;
`endif
        if (rq && allowed) begin
            n.v = -jv; n.og = 1'b0;
            if (!s.og) n.air = 1'b1;
        end else if (s.v >= 0 && solid) begin
            n.v = 0; n.og = 1'b1;
        end else begin
            n.v = (s.v + 1 > VMAX) ? VMAX : s.v + 1;
            n.og = 1'b0;
        end
        n.y = s.y + n.v;
        if (n.y < CEIL) begin
            n.y = CEIL; n.v = 0;
        end else if (n.y > GROUND) begin
            n.y = GROUND; n.v = 0; n.og = 1'b1;
        end
        if (n.og) n.air = 1'b0;
        return n;
    endfunction

    task automatic check_outputs(input string sfx);
        check({"ypos_a", sfx}, y_a, ma.y);
        check({"vel_a", sfx},  v_a, ma.v);
        check({"og_a", sfx},   og_a, int'(ma.og));
        check({"ypos_b", sfx}, y_b, mb.y);
        check({"vel_b", sfx},  v_b, mb.v);
        check({"og_b", sfx},   og_b, int'(mb.og));
    endtask

    // Entered just before a tick edge; runs one whole tick period.
    task automatic run_period(input bit toggle, input int key_phase, input logic [10:0] new_x);
        int  ea = 0;
        int  eb = 0;
        bit  rose = 1'b0;
        for (int p = 0; p < TICK; p++) begin
            @(posedge clk); #1;
            if (p == 1) begin
                ea = exp_adr(ma.y, xpos);
                eb = exp_adr(mb.y, xpos);
                check("adr_a", adr_a, ea);
                check("adr_b", adr_b, eb);
                xpos = new_x;
            end
            if (toggle && p == key_phase) begin
                jump_key = ~jump_key;
                if (jump_key) rose = 1'b1;
            end
            if (p == 3) begin
                ma = commit(ma, 15, req, map_px(16'(ea)) != 4'd0);
                mb = commit(mb, 31, req, map_px(16'(eb)) != 4'd0);
                check_outputs("");
            end
        end
        req = rose;
    endtask

    task automatic check_reset_vals();
        check("rst_adr_a", adr_a, 0);
        check("rst_adr_b", adr_b, 0);
        check_outputs("_rst");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        jump_key = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ma = reset_state(); mb = reset_state(); req = 1'b0;
        check_reset_vals();
        rst = 1'b0;
        repeat (7) @(posedge clk);
    endtask

    // Reset asserted in the WAIT cycle, so the would-be UPDATE edge is a reset edge.
    task automatic mid_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        jump_key = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        ma = reset_state(); mb = reset_state(); req = 1'b0;
        check_reset_vals();
        rst = 1'b0;
        repeat (7) @(posedge clk);
    endtask

    task automatic random_periods(input int n);
        for (int i = 0; i < n; i++) begin
            logic [10:0] nx;
            if ($urandom_range(0, 3) == 0)
                nx = 11'($urandom_range(0, 2047));
            else if ($urandom_range(0, 1) == 0)
                nx = 11'($urandom_range(200, 399));
            else
                nx = xpos;
            run_period($urandom_range(0, 2) == 0, int'($urandom_range(1, 7)), nx);
        end
    endtask

    initial begin
        rst = 1'b1;
        jump_key = 1'b0;
        xpos = 11'd200;
        ma = reset_state(); mb = reset_state(); req = 1'b0;
        do_reset();

        repeat (10) run_period(1'b0, 1, 11'd200);

        // Press and hold through the whole flight, then release and press again.
        run_period(1'b1, 4, 11'd200);
        repeat (40) run_period(1'b0, 1, 11'd200);
        run_period(1'b1, 2, 11'd200);
        run_period(1'b1, 1, 11'd200);
        repeat (40) run_period(1'b0, 1, 11'd600);

        random_periods(400);

        if (jump_key) run_period(1'b1, 3, xpos);
        repeat (20) run_period(1'b0, 1, xpos);
        run_period(1'b1, 5, xpos);
        run_period(1'b1, 2, xpos);
        mid_reset();

        random_periods(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_physics_y.md
# player_physics_y

Parametrised vertical-motion engine for the player sprite. It integrates a signed velocity under gravity once per physics tick and launches jumps on key press edges. Landing is resolved against the background tile map, read through a one-cycle-latency pixel port, and against a fixed ground line. It sits between the keyboard decoder and the sprite draw stage, and shares the map ROM read port with the renderer.

## Interface
Parameters:
- `TICK_CYCLES`, 2000000: clk cycles per physics tick; must be ≥ 4.
- `Y_W`, 10: width of the vertical position.
- `V_W`, 6: width of the signed velocity in px/tick.
- `GROUND_Y`, 448: lowest legal Y (floor line).
- `CEIL_Y`, 20: highest legal Y (smallest value).
- `JUMP_V`, 15: jump impulse magnitude; velocity is set to −JUMP_V.
- `GRAVITY`, 1: velocity increment per tick.
- `VMAX_FALL`, 8: maximum positive velocity.
- `MAP_ROW_OFS`, 2: row offset added to the map row index (foot probe).

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- jump_key, in, 1: level, high while the jump key is held.
- xpos, in, 11: player X position in px.
- rgb_pixel, in, 4: map pixel at `pixel_adr`, valid 1 cycle after the address.
- pixel_adr, out, 16: map address; [8:0] = xpos>>2, [15:9] = ((player_ypos>>2)+MAP_ROW_OFS) truncated to 7 bits.
- player_ypos, out, Y_W: current Y (top of sprite).
- velocity, out, V_W signed: current vertical velocity; positive is down.
- on_ground, out, 1: player is resting on the floor or a solid tile.

## Operation
- Tick counter runs 0..TICK_CYCLES−1 and wraps. `tick` fires on the terminal count. The counter never stalls.
- FSM states:
  - IDLE → ADDR on `tick`.
  - ADDR registers `pixel_adr` from current xpos/player_ypos → WAIT.
  - WAIT covers the ROM latency → UPDATE.
  - UPDATE commits new y/velocity/on_ground → IDLE.
- Jump request: `jump_key` is registered and its rising edge sets `jump_req`. `jump_req` clears only in UPDATE. A held key does not re-trigger.
- Solid test, evaluated in UPDATE: `solid = (rgb_pixel != 0) || (player_ypos >= GROUND_Y)`.
- UPDATE priority:
  1. `jump_req && jump_allowed` → v = −JUMP_V, on_ground = 0.
  2. Else if v ≥ 0 and solid → v = 0, on_ground = 1, y unchanged.
  3. Else v = min(v + GRAVITY, VMAX_FALL), on_ground = 0.
- Position: y_new = y + v, computed at Y_W+1 bits signed, then clamped to [CEIL_Y, GROUND_Y].
  - Clamping at CEIL_Y forces v = 0.
  - Clamping at GROUND_Y forces v = 0 and on_ground = 1.
- `jump_allowed = on_ground` (base build).

## Timing
- Reset values: player_ypos = GROUND_Y, velocity = 0, on_ground = 1, pixel_adr = 0, state IDLE, tick counter 0, jump_req 0.
- Latency:
  - Address changes 1 cycle after `tick`.
  - Outputs update 3 cycles after `tick`.
  - Outputs are stable across the remaining TICK_CYCLES−3 cycles.
- A key edge arriving in the same cycle as UPDATE is kept for the next tick. It is not lost.
- Reset mid-sequence (ADDR/WAIT/UPDATE) aborts with no partial commit.
- xpos changes during WAIT are ignored. The address was latched in ADDR.

## Configuration
- `PLAYER_DOUBLE_JUMP_EN`:
  - Defined: one extra airborne jump per flight. An `air_jump_used` flag sets on the airborne jump and clears when on_ground becomes 1 or on reset. `jump_allowed = on_ground || !air_jump_used`.
  - Undefined: the flag logic is absent and airborne jump requests are discarded (cleared in UPDATE).

## Test plan
- Reset, TICK_CYCLES=8 → ypos 448, velocity 0, on_ground 1. Idle 10 ticks → unchanged.
- Jump edge from ground → next UPDATE: v = −15, ypos 433. Following ticks: v −14, −13, …. Apex, then v caps at +8. Lands at ypos 448, v 0, on_ground 1.
- Key held high through landing → no second jump. Release and press → new jump.
- Fall with rgb_pixel = 4'h3 at ypos 300 (v ≥ 0) → v 0, ypos 300, on_ground 1. pixel_adr[15:9] = 77, [8:0] = xpos>>2.
- Start at ypos 25, v −15 → ypos clamps to 20, v 0.
- Airborne second press: with `PLAYER_DOUBLE_JUMP_EN` → v = −15. A third press → ignored. Without the macro → ignored.
